// File: rtl/and_gate.sv
// and_gate: bitwise AND with combinational output, plus a registered copy carrying valid and reduction flags.
// Define AND_GATE_CNT_EN to build the saturating all-ones hit counter; otherwise hit_cnt is tied to 0.
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             all_ones,
    output logic             any_one,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [WIDTH-1:0] y_q_reg;
    logic [WIDTH-1:0] y_q_next;
    logic             out_valid_reg;
    logic             out_valid_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = a[gi] & b[gi];
        end
    endgenerate

    // The result holds its value while idle; only the valid flag drops.
    always_comb begin
        y_q_next       = y_q_reg;
        out_valid_next = 1'b0;
        if (in_valid) begin
            y_q_next       = y;
            out_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            y_q_reg       <= y_q_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign y_q       = y_q_reg;
    assign out_valid = out_valid_reg;
    assign all_ones  = out_valid_reg & (&y_q_reg);
    assign any_one   = out_valid_reg & (|y_q_reg);

`ifdef AND_GATE_CNT_EN
    logic [CNT_W-1:0] hit_cnt_reg;
    logic [CNT_W-1:0] hit_cnt_next;

    // Saturate at the all-ones count rather than wrapping.
    always_comb begin
        hit_cnt_next = hit_cnt_reg;
        if (in_valid && (&y) && (hit_cnt_reg != {CNT_W{1'b1}}))
            hit_cnt_next = hit_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            hit_cnt_reg <= '0;
        else
            hit_cnt_reg <= hit_cnt_next;
    end

    assign hit_cnt = hit_cnt_reg;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: directed steps followed by random traffic, checked against a behavioural model.
// Two instances: WIDTH=1 with default counter width, and WIDTH=8 with CNT_W=2 to reach saturation quickly.
module tb_and_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic [0:0]  a1, b1;
    logic [7:0]  a8, b8;

    logic [0:0]  y1, yq1;
    logic        ov1, ao1, an1;
    logic [15:0] cnt1;
    logic [7:0]  y8, yq8;
    logic        ov8, ao8, an8;
    logic [1:0]  cnt8;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int m_yq1, m_ov1, m_cnt1;
    int m_yq8, m_ov8, m_cnt8;

    always #5 clk = ~clk;

    and_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(iv),
        .y(y1), .y_q(yq1), .out_valid(ov1), .all_ones(ao1), .any_one(an1), .hit_cnt(cnt1)
    );

    and_gate #(.WIDTH(8), .CNT_W(2)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(iv),
        .y(y8), .y_q(yq8), .out_valid(ov8), .all_ones(ao8), .any_one(an8), .hit_cnt(cnt8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model from the inputs present at the edge, then check everything.
    task automatic tick(input string tag);
        int p1, p8, e_cnt1, e_cnt8;
        @(posedge clk);
        p1 = int'(a1) * int'(b1);
        p8 = int'(a8 & b8);
        if (rst) begin
            m_yq1 = 0; m_ov1 = 0; m_cnt1 = 0;
            m_yq8 = 0; m_ov8 = 0; m_cnt8 = 0;
        end else if (iv) begin
            m_yq1 = p1; m_ov1 = 1;
            m_yq8 = p8; m_ov8 = 1;
            if (p1 == 1 && m_cnt1 < 65535) m_cnt1++;
            if (p8 == 255 && m_cnt8 < 3) m_cnt8++;
        end else begin
            m_ov1 = 0;
            m_ov8 = 0;
        end
`ifdef AND_GATE_CNT_EN
        e_cnt1 = m_cnt1;
        e_cnt8 = m_cnt8;
`else
        e_cnt1 = 0;
        e_cnt8 = 0;
`endif
        #1;
        $display("%s: rst=%0b iv=%0b a8=%02h b8=%02h y_q=%02h ov=%0b all=%0b any=%0b cnt=%0d",
                 tag, rst, iv, a8, b8, yq8, ov8, ao8, an8, cnt8);
        chk({tag, "_yq8"},  32'(yq8),  32'(m_yq8));
        chk({tag, "_ov8"},  32'(ov8),  32'(m_ov8));
        chk({tag, "_all8"}, 32'(ao8),  32'((m_ov8 == 1 && m_yq8 == 255) ? 1 : 0));
        chk({tag, "_any8"}, 32'(an8),  32'((m_ov8 == 1 && m_yq8 != 0) ? 1 : 0));
        chk({tag, "_cnt8"}, 32'(cnt8), 32'(e_cnt8));
        chk({tag, "_yq1"},  32'(yq1),  32'(m_yq1));
        chk({tag, "_ov1"},  32'(ov1),  32'(m_ov1));
        chk({tag, "_all1"}, 32'(ao1),  32'((m_ov1 == 1 && m_yq1 == 1) ? 1 : 0));
        chk({tag, "_any1"}, 32'(an1),  32'((m_ov1 == 1 && m_yq1 == 1) ? 1 : 0));
        chk({tag, "_cnt1"}, 32'(cnt1), 32'(e_cnt1));
        chk({tag, "_y8"},   32'(y8),   32'(p8));
    endtask

    initial begin
        logic [1:0] tt [4];
        logic [0:0] exp_y [4];
        tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b10; tt[3] = 2'b11;
        exp_y[0] = 1'b0; exp_y[1] = 1'b0; exp_y[2] = 1'b0; exp_y[3] = 1'b1;

        rst = 1'b1; iv = 1'b0; a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        m_yq1 = 0; m_ov1 = 0; m_cnt1 = 0; m_yq8 = 0; m_ov8 = 0; m_cnt8 = 0;

        // Truth table on the 1-bit gate, before any clock edge
        for (int i = 0; i < 4; i++) begin
            a1 = tt[i][1];
            b1 = tt[i][0];
            #1;
            $display("tt: a=%0b b=%0b y=%0b", a1, b1, y1);
            chk($sformatf("tt%0d_y1", i), 32'(y1), 32'(exp_y[i]));
        end
        a1 = '0; b1 = '0;

        // Reset held for two edges
        tick("rst0");
        tick("rst1");
        chk("rst_yq8", 32'(yq8), 32'h0);
        chk("rst_cnt8", 32'(cnt8), 32'h0);
        rst = 1'b0;

        // Partial overlap pattern
        iv = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
        #1;
        chk("t3_y_comb", 32'(y8), 32'h30);
        tick("t3");
        chk("t3_yq", 32'(yq8), 32'h30);
        chk("t3_all", 32'(ao8), 32'h0);
        chk("t3_any", 32'(an8), 32'h1);

        // All-ones capture then idle: flag for one cycle, y_q held
        a8 = 8'hFF; b8 = 8'hFF;
        tick("t4_valid");
        chk("t4_all", 32'(ao8), 32'h1);
        iv = 1'b0;
        tick("t4_idle");
        chk("t4_hold_yq", 32'(yq8), 32'hFF);
        chk("t4_idle_all", 32'(ao8), 32'h0);

        // Saturation run after a clean reset
        rst = 1'b1;
        tick("t5_rst");
        rst = 1'b0; iv = 1'b1; a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1;
        for (int i = 0; i < 5; i++) tick($sformatf("t5_sat%0d", i));
        iv = 1'b0;
        rst = 1'b1;
        tick("t5_clr");
        chk("t5_clr_cnt", 32'(cnt8), 32'h0);

        // Reset beats valid on the same edge; combinational path stays live
        rst = 1'b1; iv = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        tick("t6");
        chk("t6_yq", 32'(yq8), 32'h0);
        chk("t6_ov", 32'(ov8), 32'h0);
        chk("t6_y", 32'(y8), 32'hFF);

        // Random traffic, biased so all-ones operands show up regularly
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 29) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            tick($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
